// File: rtl/serial_addsub_pkg.sv
// -----------------------------------------------------------------------------
// serial_addsub_pkg
//   Shared types and helpers for the bit-serial adder/subtractor.
//   - state_t   : FSM state encoding (IDLE / RUN / DONE)
//   - cnt_width : width of a counter that must reach the value 'width'
//   - sat_pos   : most positive two's-complement value of a given width
//   - sat_neg   : most negative two's-complement value of a given width
//                 (both returned zero-extended to 64 bits; callers truncate)
// -----------------------------------------------------------------------------
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The bit counter runs 0..width inclusive, so it needs room for 'width'.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic logic [63:0] sat_pos(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_neg(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// -----------------------------------------------------------------------------
// serial_fa_cell
//   Purely combinational 1-bit full adder used by the serial datapath.
//   Ports:
//     a, b  : operand bits
//     cin   : carry in
//     sum   : a ^ b ^ cin
//     cout  : majority(a, b, cin)
// -----------------------------------------------------------------------------
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub.sv
// -----------------------------------------------------------------------------
// serial_addsub
//   Bit-serial two's-complement adder/subtractor. One bit pair is added per
//   clock, LSB first, through a single full-adder cell and a registered carry.
//   Subtraction is a + ~b + 1 (operand inverted at capture, carry seeded to 1).
//
//   Optional feature (compile-time macro SERIAL_ADDSUB_SAT_EN):
//     when defined, an overflowing result saturates to the most positive or
//     most negative value; ovf and cout always report the raw flags.
//
//   Parameters:
//     WIDTH  : operand/result width, 2..64
//   Ports:
//     clk    : clock, all state updates on the rising edge
//     rst    : synchronous active-high reset
//     start  : begin an operation (honoured only when idle)
//     sub    : 0 = a + b, 1 = a - b
//     a, b   : two's-complement operands, sampled with start
//     busy   : high while an operation is running or completing
//     done   : one-cycle pulse when result/ovf/cout are updated
//     result : result of the last completed operation
//     ovf    : signed overflow of the last completed operation
//     cout   : unsigned carry out of the MSB of the last completed operation
//
//   Timing: start sampled at edge T -> WIDTH bit cycles -> done high in the
//   cycle following edge T+WIDTH+1.
// -----------------------------------------------------------------------------
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             cout
);

  localparam int CW = cnt_width(WIDTH);

`ifdef SERIAL_ADDSUB_SAT_EN
  localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(sat_pos(WIDTH));
  localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(sat_neg(WIDTH));
`endif

  state_t           state_q,   state_d;
  logic [WIDTH-1:0] a_q,       a_d;
  logic [WIDTH-1:0] b_q,       b_d;
  logic [WIDTH-1:0] sum_q,     sum_d;
  logic             carry_q,   carry_d;
  logic             msb_cin_q, msb_cin_d;
  logic [CW-1:0]    cnt_q,     cnt_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic [WIDTH-1:0] result_q,  result_d;
  logic             ovf_q,     ovf_d;
  logic             cout_q,    cout_d;

  logic fa_sum;
  logic fa_cout;

  // Operand registers shift right each bit cycle, so bit 0 is always the
  // current bit pair.
  serial_fa_cell u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    msb_cin_d = msb_cin_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    result_d  = result_q;
    ovf_d     = ovf_q;
    cout_d    = cout_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        if (cnt_q == CW'(WIDTH)) begin
          // All bits processed: carry_q is the carry out of the MSB and
          // msb_cin_q the carry that went into it.
          state_d  = DONE;
          done_d   = 1'b1;
          result_d = sum_q;
          ovf_d    = msb_cin_q ^ carry_q;
          cout_d   = carry_q;
`ifdef SERIAL_ADDSUB_SAT_EN
          // A raw MSB of 1 on overflow means the true result was positive.
          if (msb_cin_q ^ carry_q) begin
            result_d = sum_q[WIDTH-1] ? SAT_POS : SAT_NEG;
          end
`endif
        end else begin
          a_d     = a_q >> 1;
          b_d     = b_q >> 1;
          // Sum bits enter at the top; after WIDTH shifts bit 0 is the LSB.
          sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
          carry_d = fa_cout;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            msb_cin_d = carry_q;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of its _d input.
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      msb_cin_q <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
      cout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      msb_cin_q <= msb_cin_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      ovf_q     <= ovf_d;
      cout_q    <= cout_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign ovf    = ovf_q;
  assign cout   = cout_q;

endmodule

// File: tb/tb_serial_addsub.sv
// -----------------------------------------------------------------------------
// tb_serial_addsub
//   Self-checking bench for serial_addsub (WIDTH = 8). The driver issues
//   operations and pushes the expected response, computed with plain integer
//   arithmetic, into a queue; a monitor pops and compares on every done pulse.
//   Honours SERIAL_ADDSUB_SAT_EN in the reference model.
// -----------------------------------------------------------------------------
module tb_serial_addsub;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             ovf;
    logic             cout;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             ovf;
  logic             cout;

  exp_t             sb_q[$];
  int               n_checks = 0;
  int               n_errors = 0;
  int               n_done   = 0;
  logic [WIDTH-1:0] last_res;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .ovf    (ovf),
    .cout   (cout)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: true signed result and unsigned sum from integer math.
  function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                 input logic s);
    exp_t           e;
    int             sa;
    int             sbv;
    int             tv;
    logic [WIDTH:0] u;
    sa  = $signed(av);
    sbv = $signed(bv);
    tv  = s ? sa - sbv : sa + sbv;
    if (s) u = {1'b0, av} + {1'b0, ~bv} + (WIDTH+1)'(1);
    else   u = {1'b0, av} + {1'b0, bv};
    e.res  = u[WIDTH-1:0];
    e.cout = u[WIDTH];
    e.ovf  = (tv > (2**(WIDTH-1)) - 1) || (tv < -(2**(WIDTH-1)));
`ifdef SERIAL_ADDSUB_SAT_EN
    if (e.ovf) e.res = (tv > 0) ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
`endif
    return e;
  endfunction

  // Monitor: compares every done pulse against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      n_done++;
      if (sb_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("result", 64'(result), 64'(e.res));
        check("ovf",    64'(ovf),    64'(e.ovf));
        check("cout",   64'(cout),   64'(e.cout));
      end
    end
  end

  // Issue one operation from IDLE. mid_start re-pulses start with different
  // operands so that it is sampled at edge T+3; it must be ignored.
  task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic s, input bit mid_start);
    exp_t e;
    int   lat;
    bit   hold_ok;
    int   d0;
    e = model(av, bv, s);
    sb_q.push_back(e);
    d0    = n_done;
    a     = av;
    b     = bv;
    sub   = s;
    start = 1'b1;
    @(posedge clk); #1;  // edge T
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    lat     = 0;
    hold_ok = 1'b1;
    for (int k = 1; k <= 3 * WIDTH && lat == 0; k++) begin
      if (mid_start && k == 3) begin
        start = 1'b1;
        a     = $urandom;
        b     = $urandom;
        sub   = ~s;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        lat = k;
        check("busy_in_done", 64'(busy), 64'd1);
      end else if (result !== last_res) begin
        hold_ok = 1'b0;
      end
    end
    check("latency", 64'(lat), 64'(WIDTH + 1));
    check("result_hold", 64'(hold_ok), 64'd1);
    last_res = e.res;
    @(posedge clk); #1;
    check("busy_idle", 64'(busy), 64'd0);
    if (mid_start) begin
      @(posedge clk); #1;
      check("single_done", 64'(n_done - d0), 64'd1);
    end
  endtask

  // Start an operation and reset it at edge T+4.
  task automatic run_reset_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                              input logic s);
    int d0;
    a     = av;
    b     = bv;
    sub   = s;
    start = 1'b1;
    @(posedge clk); #1;  // edge T
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;  // edge T+4
    check("rst_busy",   64'(busy),   64'd0);
    check("rst_done",   64'(done),   64'd0);
    check("rst_result", 64'(result), 64'd0);
    rst      = 1'b0;
    last_res = '0;
    d0       = n_done;
    repeat (WIDTH + 4) begin
      @(posedge clk); #1;
    end
    check("no_done_after_rst", 64'(n_done - d0), 64'd0);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    sub      = 1'b0;
    a        = '0;
    b        = '0;
    last_res = '0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("reset_busy",   64'(busy),   64'd0);
    check("reset_done",   64'(done),   64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_ovf",    64'(ovf),    64'd0);
    check("reset_cout",   64'(cout),   64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases, including the overflow and carry boundaries.
    run_op(8'd5,   8'd3,   1'b0, 1'b0);
    run_op(8'd100, 8'd50,  1'b0, 1'b0);
    run_op(8'h80,  8'h01,  1'b1, 1'b0);
    run_op(8'hFF,  8'h01,  1'b0, 1'b0);
    run_op(8'hFD,  8'hFC,  1'b1, 1'b0);
    run_op(8'h00,  8'h80,  1'b1, 1'b0);
    run_op(8'h7F,  8'h01,  1'b0, 1'b0);
    run_op(8'h80,  8'h80,  1'b0, 1'b0);
    run_op(8'h12,  8'h34,  1'b0, 1'b1);
    run_reset_op(8'd5, 8'd3, 1'b0);
    run_op(8'd5,   8'd3,   1'b0, 1'b0);

    // Randomized operations.
    for (int i = 0; i < 40; i++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0);
    end

    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
